// File: rtl/fft_config_master.sv
// Drives one FFT IP configuration word over AXI-Stream per rising edge of cfg_start,
// then pulses cfg_done after a settle interval. Optional macro: FFT_CFG_NFFT_EN adds cfg_nfft.
module fft_config_master #(
  parameter int CFG_WIDTH = 16,
  parameter int SCALE_WIDTH = 10,
  parameter logic [SCALE_WIDTH-1:0] SCALE_FWD = 10'b1010101011,
  parameter logic [SCALE_WIDTH-1:0] SCALE_INV = 10'b0000000000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_start,
  input  logic                 cfg_fwd_inv,
`ifdef FFT_CFG_NFFT_EN
  input  logic [4:0]           cfg_nfft,
`endif
  output logic                 cfg_done,
  output logic                 cfg_busy,
  output logic                 cfg_overrun,
  output logic [7:0]           cfg_count,
  output logic                 m_axis_config_tvalid,
  input  logic                 m_axis_config_tready,
  output logic [CFG_WIDTH-1:0] m_axis_config_tdata,
  output logic [1:0]           fsm_state
);

  // Handshake: the word transfers on any edge where tvalid and tready are both high;
  // tvalid never drops and tdata never changes while a transfer is pending.

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEND   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
`ifdef FFT_CFG_NFFT_EN
  localparam int PACK_W = SCALE_WIDTH + 9;
`else
  localparam int PACK_W = SCALE_WIDTH + 1;
`endif

  logic [1:0]             state;
  logic                   start_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [SCALE_WIDTH-1:0] scale;
  logic [PACK_W-1:0]      packed_word;

  assign rise                 = cfg_start & ~start_d;
  assign cfg_busy             = (state != IDLE);
  assign cfg_done             = (state == DONE);
  assign m_axis_config_tvalid = (state == SEND);
  assign fsm_state            = state;

`ifdef FFT_CFG_NFFT_EN
  logic [4:0] nfft_clamped;
  always_comb begin
    nfft_clamped = cfg_nfft;
    if (cfg_nfft < 5'd3)       nfft_clamped = 5'd3;
    else if (cfg_nfft > 5'd16) nfft_clamped = 5'd16;
  end
`endif

  always_comb begin
    scale       = cfg_fwd_inv ? SCALE_FWD : SCALE_INV;
    packed_word = '0;
`ifdef FFT_CFG_NFFT_EN
    packed_word[4:0]             = nfft_clamped;
    packed_word[8]               = cfg_fwd_inv;
    packed_word[SCALE_WIDTH+8:9] = scale;
`else
    packed_word[0]             = cfg_fwd_inv;
    packed_word[SCALE_WIDTH:1] = scale;
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state               <= IDLE;
      start_d             <= 1'b0;
      cnt                 <= '0;
      cfg_overrun         <= 1'b0;
      cfg_count           <= 8'd0;
      m_axis_config_tdata <= '0;
    end else begin
      start_d <= cfg_start;
      // Any edge arriving while busy is dropped but remembered.
      if (rise && state != IDLE)
        cfg_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (rise) begin
            m_axis_config_tdata <= CFG_WIDTH'(packed_word);
            state               <= SEND;
          end
        end
        SEND: begin
          if (m_axis_config_tready) begin
            if (SETTLE_CYCLES == 0) begin
              state <= DONE;
            end else begin
              cnt   <= CNT_W'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          cfg_count <= cfg_count + 8'd1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
